// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: memory port, decode handshake, redirect, status.
// Latency: wires only, no storage.
// Backpressure: carries dec_ready from decode back to the sequencer.
//
// Signals:
//   start                 one-cycle pulse that begins fetching from IDLE
//   imem_addr/imem_data   instruction memory address out, word back (combinational)
//   dec_valid/dec_ready   queue head handshake toward decode
//   dec_instr/dec_pc      queue head instruction and its PC
//   redirect/redirect_pc  taken-branch redirect from EX
//   halted, fetch_count   status outputs
interface fetch_sequencer_if;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    // Sequencer side.
    modport master (
        input  start, imem_data, dec_ready, redirect, redirect_pc,
        output imem_addr, dec_valid, dec_instr, dec_pc, halted, fetch_count
    );

    // Environment side: memory, decode, execute.
    modport slave (
        output start, imem_data, dec_ready, redirect, redirect_pc,
        input  imem_addr, dec_valid, dec_instr, dec_pc, halted, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches 16-bit words into a 2-entry queue for decode.
// Latency: word at imem_addr in cycle N is at the decode head in cycle N+1 (empty queue); +1 after redirect.
// Backpressure: dec_ready low fills the queue, then PC and imem_addr hold until a pop frees a slot.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   sq     fetch_sequencer_if.master (start, imem_*, dec_*, redirect*, halted, fetch_count)
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  sq
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [1:0] QFULL     = 2'(QDEPTH);
    localparam logic [15:0] HALT_OP  = 16'h0000;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [1:0]  count;
    logic [15:0] fcnt;

    // Entry 0 is always the head so decode sees it with no mux or extra latency.
    logic [15:0] q0_instr, q0_pc;
    logic [15:0] q1_instr, q1_pc;

    logic        pop;
    logic        room;
    logic        push;
    logic        is_halt;
    logic [15:0] redir_pc;

    assign pop      = (count != 2'd0) && sq.dec_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign room     = (count < QFULL) || pop;
    assign push     = (state == ST_FETCH) && !sq.redirect && room;
    assign is_halt  = (sq.imem_data == HALT_OP);
    // Instructions sit on even addresses only.
    assign redir_pc = {sq.redirect_pc[15:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            count    <= 2'd0;
            fcnt     <= 16'h0000;
            q0_instr <= 16'h0000;
            q0_pc    <= 16'h0000;
            q1_instr <= 16'h0000;
            q1_pc    <= 16'h0000;
        end else if (state == ST_IDLE) begin
            // The queue is already empty here; redirect only retargets the PC.
            if (sq.redirect) begin
                pc <= redir_pc;
            end else if (sq.start) begin
                state <= ST_FETCH;
            end
        end else if (sq.redirect) begin
            // Flush wins over any push or pop in the same cycle.
            count <= 2'd0;
            pc    <= redir_pc;
            state <= ST_FETCH;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q0_instr <= sq.imem_data;
                        q0_pc    <= pc;
                    end else begin
                        q1_instr <= sq.imem_data;
                        q1_pc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0_instr <= q1_instr;
                    q0_pc    <= q1_pc;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0_instr <= sq.imem_data;
                        q0_pc    <= pc;
                    end else begin
                        q0_instr <= q1_instr;
                        q0_pc    <= q1_pc;
                        q1_instr <= sq.imem_data;
                        q1_pc    <= pc;
                    end
                end
                default: ;
            endcase

            if (push) begin
                if (fcnt != 16'hFFFF) begin
                    fcnt <= fcnt + 16'd1;
                end
                // HALT is still queued so decode sees it; the PC parks on it.
                if (is_halt) begin
                    state <= ST_HALTED;
                end else begin
                    pc <= pc + PC_STEP;
                end
            end
        end
    end

    assign sq.imem_addr   = pc;
    assign sq.dec_valid   = (count != 2'd0);
    assign sq.dec_instr   = q0_instr;
    assign sq.dec_pc      = q0_pc;
    assign sq.halted      = (state == ST_HALTED);
    assign sq.fetch_count = fcnt;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 16-bit instruction memory for the pipelined CPU.
- Owns the PC and drives the memory address. The memory read is combinational, so its data is valid in the same cycle.
- Buffers fetched words in a 2-entry queue that feeds decode over a valid/ready handshake.
- Handles branch redirect, queue flush, HALT (opcode word 16'h0000) detection and a fetched-instruction counter.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per instruction. Memory is byte-addressed with one 16-bit word at each even address.
- QDEPTH, 2, instruction queue depth (fixed at 2 for this revision).

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that leaves IDLE and begins fetching.
- imem_addr, out, 16, PC presented to instruction memory.
- imem_data, in, 16, instruction word returned combinationally for imem_addr.
- dec_valid, out, 1, queue head is valid.
- dec_ready, in, 1, decode accepts the head this cycle.
- dec_instr, out, 16, queue head instruction.
- dec_pc, out, 16, PC of queue head.
- redirect, in, 1, branch resolved taken (from EX).
- redirect_pc, in, 16, branch target.
- halted, out, 1, high while the sequencer is in HALTED.
- fetch_count, out, 16, number of instructions pushed into the queue; saturates at 16'hFFFF.

Behaviour:
- One clock domain. rst_n is asynchronous and active-low. Asserting rst_n at any time, including mid-fetch or mid-redirect, immediately clears:
  - state to IDLE
  - pc to RESET_PC
  - queue to empty
  - dec_valid, halted and fetch_count to 0
  - dec_instr and dec_pc to 16'h0000
- imem_addr = pc at all times (combinational from the pc register).
- States:
  - IDLE: no push. start moves to FETCH on the next edge. redirect in IDLE loads pc and stays in IDLE.
  - FETCH: a push occurs when the queue has room this cycle, i.e. count<2, or count==2 with a pop (dec_valid & dec_ready) this cycle.
    - A push writes {imem_data, pc} at the tail, then pc <= pc+PC_STEP and fetch_count increments (saturating).
    - If the pushed word == 16'h0000: the word is still queued so decode sees HALT, pc holds at the HALT address, and the state goes to HALTED.
  - HALTED: no push; halted=1; the queue continues to drain to decode. redirect returns the state to FETCH.
- Pop: when dec_valid & dec_ready, the head is removed at the edge. Push and pop in the same cycle keep the count unchanged, and ordering is strictly FIFO.
- dec_valid = (count!=0). dec_instr and dec_pc come directly from the head entry, giving zero added latency from queue to decode.
- Fetch latency: a word at imem_addr in cycle N appears at the decode head in cycle N+1 when the queue was empty.
- Redirect has highest priority and applies in any state except IDLE handling above. In its cycle:
  - The queue is flushed to count=0.
  - No push occurs, and a pop in the same cycle is discarded.
  - pc <= {redirect_pc[15:1], 1'b0}; an odd target is forced even.
  - The state goes to FETCH (from FETCH or HALTED).
  - The first post-redirect word reaches the head one cycle later than normal.
- Redirect coinciding with a HALT fetch: redirect wins, the HALT word is not queued, and the state stays in FETCH.
- PC wrap: 16'hFFFE + 2 -> 16'h0000, silently.
- No push and no pc change while the queue is full and not popping; the memory address is held stable.

Test Plan:
- Reset, start pulse, memory holds 16'hFE21 @0, 16'hFB22 @2, 16'h2388 @4, dec_ready=1 -> dec_valid from the 2nd cycle after start; dec_instr/dec_pc sequence FE21/0, FB22/2, 2388/4; fetch_count=3.
- dec_ready=0 for 5 cycles after start -> queue fills with 2 entries; imem_addr holds at 16'h0004; fetch_count=2; on release, entries drain in order with no loss or duplication.
- redirect=1, redirect_pc=16'h0023 while the queue holds 2 entries -> queue flushed (dec_valid=0 the next cycle), imem_addr=16'h0022, next dec_pc=16'h0022.
- Word 16'h0000 at address 62 -> it is queued with dec_pc=62, halted=1, imem_addr stays 62; later redirect_pc=16'h0010 -> halted=0 and fetch resumes at 16'h0010.
- rst_n asserted low mid-fetch, asynchronously between edges -> all outputs clear immediately; after release and start, fetch restarts at RESET_PC.
- Redirect in the same cycle as a HALT fetch -> halted stays 0 and the HALT word never appears on dec_instr.
